// File: rtl/sigmoid_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid_pwl_pipe
// Purpose  : Fixed-point piecewise-linear sigmoid for the neuron activation
//            path. The segments use only shifts and adds. Negative inputs
//            are handled by symmetry: y(-x) = 1 - y(x).
//            This is a 3-stage valid/ready pipeline with one global enable.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - input handshake (x_in, tag_in)
//            x_in                - signed Q(X_FRAC) argument
//            tag_in / tag_out    - sideband tag, passed through unchanged
//            out_valid/out_ready - output handshake (y_out, tag_out)
//            y_out               - unsigned Q(Y_FRAC) result in [0, 1.0]
//            dy_out              - y*(1-y), present only with SIGMOID_DERIV_EN
// Options  : `define SIGMOID_DERIV_EN adds dy_out and a 4th stage.
// Revision : 1.0 - initial release
// ============================================================================
module sigmoid_pwl_pipe #(
    parameter int X_W    = 16,
    parameter int X_FRAC = 12,
    parameter int Y_W    = 16,
    parameter int Y_FRAC = 15,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X_W-1:0]   x_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Y_W-1:0]   y_out,
`ifdef SIGMOID_DERIV_EN
    output logic [Y_W-1:0]   dy_out,
`endif
    output logic [TAG_W-1:0] tag_out
);

    // The segment value f is held with one guard bit above X_W.
    localparam int FW = X_W + 1;
    // This is the alignment from the input to the output fraction.
    // It is exact because Y_FRAC >= X_FRAC.
    localparam int SH = Y_FRAC - X_FRAC;
    localparam int EW = FW + SH;

    // The segment thresholds and offsets are in Q(X_FRAC).
    localparam logic [FW-1:0] ONE_X   = FW'(1 << X_FRAC);
    localparam logic [FW-1:0] THR_S2  = FW'((19 << X_FRAC) >> 3);  // 2.375
    localparam logic [FW-1:0] THR_S3  = FW'(5 << X_FRAC);          // 5.0
    localparam logic [FW-1:0] OFF_S0  = FW'((1 << X_FRAC) >> 1);   // 0.5
    localparam logic [FW-1:0] OFF_S1  = FW'((5 << X_FRAC) >> 3);   // 0.625
    localparam logic [FW-1:0] OFF_S2  = FW'((27 << X_FRAC) >> 5);  // 0.84375
    localparam logic [EW-1:0] ONE_Y   = {{(EW-1){1'b0}}, 1'b1} << Y_FRAC;
    localparam logic [X_W-1:0] MAX_POS = {1'b0, {(X_W-1){1'b1}}};

    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // Stage 1: sign and saturating absolute value
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_sign_q;
    logic [X_W-1:0]   s1_abs_q, s1_abs_d, w_neg;
    logic [TAG_W-1:0] s1_tag_q;

    // Negating the most-negative code returns a value with the sign bit
    // still set. That is the single case that must saturate.
    assign w_neg = -x_in;

    always_comb begin
        s1_abs_d = x_in;
        if (x_in[X_W-1]) begin
            s1_abs_d = w_neg[X_W-1] ? MAX_POS : w_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_abs_q   <= '0;
            s1_tag_q   <= '0;
        end else if (w_en) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= x_in[X_W-1];
            s1_abs_q   <= s1_abs_d;
            s1_tag_q   <= tag_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: segment select and shift-add
    // ------------------------------------------------------------------
    logic             s2_valid_q, s2_sign_q;
    logic [FW-1:0]    s2_f_q, s2_f_d, w_a;
    logic [TAG_W-1:0] s2_tag_q;

    assign w_a = {1'b0, s1_abs_q};

    // A value on a boundary goes to the upper segment.
    always_comb begin
        s2_f_d = ONE_X;
        if (w_a < ONE_X) begin
            s2_f_d = (w_a >> 2) + OFF_S0;
        end else if (w_a < THR_S2) begin
            s2_f_d = (w_a >> 3) + OFF_S1;
        end else if (w_a < THR_S3) begin
            s2_f_d = (w_a >> 5) + OFF_S2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_f_q     <= '0;
            s2_tag_q   <= '0;
        end else if (w_en) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_f_q     <= s2_f_d;
            s2_tag_q   <= s1_tag_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: align to Q(Y_FRAC), clamp, apply symmetry
    // ------------------------------------------------------------------
    logic             s3_valid_q;
    logic [Y_W-1:0]   s3_y_q, s3_y_d;
    logic [TAG_W-1:0] s3_tag_q;
    logic [EW-1:0]    w_f_al, w_f_cl, w_y_full;

    assign w_f_al = EW'(s2_f_q) << SH;
    // f never exceeds 1.0 by construction. The clamp guarantees the
    // subtraction below can never go negative.
    assign w_f_cl   = (w_f_al > ONE_Y) ? ONE_Y : w_f_al;
    assign w_y_full = s2_sign_q ? (ONE_Y - w_f_cl) : w_f_cl;
    assign s3_y_d   = Y_W'(w_y_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_y_q     <= '0;
            s3_tag_q   <= '0;
        end else if (w_en) begin
            s3_valid_q <= s2_valid_q;
            s3_y_q     <= s3_y_d;
            s3_tag_q   <= s2_tag_q;
        end
    end

`ifdef SIGMOID_DERIV_EN
    // ------------------------------------------------------------------
    // Stage 4: gradient y*(1-y), truncated to Q(Y_FRAC)
    // ------------------------------------------------------------------
    localparam int PW = 2 * Y_W;
    localparam logic [Y_W-1:0] ONE_YW = Y_W'(ONE_Y);

    logic             s4_valid_q;
    logic [Y_W-1:0]   s4_y_q, s4_dy_q, s4_dy_d, w_omy;
    logic [TAG_W-1:0] s4_tag_q;
    logic [PW-1:0]    w_prod;

    assign w_omy   = ONE_YW - s3_y_q;
    assign w_prod  = PW'(s3_y_q) * PW'(w_omy);
    assign s4_dy_d = Y_W'(w_prod >> Y_FRAC);

    always_ff @(posedge clk) begin
        if (rst) begin
            s4_valid_q <= 1'b0;
            s4_y_q     <= '0;
            s4_dy_q    <= '0;
            s4_tag_q   <= '0;
        end else if (w_en) begin
            s4_valid_q <= s3_valid_q;
            s4_y_q     <= s3_y_q;
            s4_dy_q    <= s4_dy_d;
            s4_tag_q   <= s3_tag_q;
        end
    end

    assign out_valid = s4_valid_q;
    assign y_out     = s4_y_q;
    assign dy_out    = s4_dy_q;
    assign tag_out   = s4_tag_q;
`else
    assign out_valid = s3_valid_q;
    assign y_out     = s3_y_q;
    assign tag_out   = s3_tag_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigmoid_pwl_pipe
// Purpose  : Self-checking bench for sigmoid_pwl_pipe. It uses directed
//            vectors with hand-computed results, backpressure, random
//            handshakes against a PWL model, and reset during a stream.
// Options  : honours SIGMOID_DERIV_EN (dy_out, latency 4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigmoid_pwl_pipe;

`ifdef SIGMOID_DERIV_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [7:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_out;
    logic [7:0]  tag_out;
`ifdef SIGMOID_DERIV_EN
    logic [15:0] dy_out;
`endif

    sigmoid_pwl_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
`ifdef SIGMOID_DERIV_EN
        .dy_out    (dy_out),
`endif
        .tag_out   (tag_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_lat  = 1'b1;
    bit rnd_done = 1'b0;

    typedef struct {
        logic [15:0] y;
        logic [7:0]  t;
        int          c;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Golden PWL model, written straight from the segment table.
    function automatic logic [15:0] model(input logic [15:0] x);
        int a, f, fy;
        a = int'($signed(x));
        if (a < 0) a = -a;
        if (a > 32767) a = 32767;
        if (a < 4096)       f = a / 4 + 2048;
        else if (a < 9728)  f = a / 8 + 2560;
        else if (a < 20480) f = a / 32 + 3456;
        else                f = 4096;
        fy = f * 8;
        if (x[15]) fy = 32768 - fy;
        return 16'(fy);
    endfunction

    task automatic send(input logic [15:0] x, input logic [7:0] t, input logic [15:0] ey);
        int w;
        exp_t e;
        in_valid = 1'b1;
        x_in     = x;
        tag_in   = t;
        w        = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.y = ey;
            e.t = t;
            e.c = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: checks each transfer against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("y_out", 32'(y_out), 32'(e.y));
                    check("tag_out", 32'(tag_out), 32'(e.t));
`ifdef SIGMOID_DERIV_EN
                    check("dy_out", 32'(dy_out),
                          32'((32'(e.y) * (32'd32768 - 32'(e.y))) >> 15));
`endif
                    if (chk_lat) check("latency", 32'(cyc - e.c), 32'(LAT));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] vx [12];
    logic [15:0] vy [12];

    initial begin
        logic [15:0] cap_y;
        logic [7:0]  cap_t;
        logic [15:0] rx;
        int          c0;

        vx = '{16'h0000, 16'h0800, 16'h1000, 16'h2600, 16'h5000, 16'hF000,
               16'h8000, 16'h7FFF, 16'h25FF, 16'h0FFF, 16'h4FFF, 16'hF800};
        vy = '{16'h4000, 16'h5000, 16'h6000, 16'h7580, 16'h8000, 16'h2000,
               16'h0000, 16'h8000, 16'h75F8, 16'h5FF8, 16'h7FF8, 16'h3000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        x_in      = '0;
        tag_in    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y_out", 32'(y_out), 32'd0);
        check("rst_tag_out", 32'(tag_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, including segment boundaries and symmetry.
        chk_lat = 1'b1;
        for (int i = 0; i < 12; i++) send(vx[i], 8'(8'h10 + i), vy[i]);
        drain();

        // Backpressure: out_ready drops for 5 cycles mid-stream.
        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(vx[i], 8'(i), vy[i]);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check("bp_valid", 32'(out_valid), 32'd1);
                cap_y = y_out;
                cap_t = tag_out;
                for (int k = 0; k < 5; k++) begin
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_y_stable", 32'(y_out), 32'(cap_y));
                    check("bp_tag_stable", 32'(tag_out), 32'(cap_t));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random valid/ready against the model.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    rx = 16'($urandom);
                    send(rx, 8'(i), model(rx));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Throughput with both sides always on.
        chk_lat = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 20; i++) send(vx[i % 12], 8'(8'h40 + i), vy[i % 12]);
        check("throughput", 32'(cyc - c0), 32'd20);
        drain();

        // Reset with two samples in flight.
        send(16'h1000, 8'hA0, 16'h6000);
        send(16'h2600, 8'hA1, 16'h7580);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(16'h0000, 8'h55, 16'h4000);
        drain();
        repeat (8) @(posedge clk);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sigmoid_pwl_pipe.md
Name: sigmoid_pwl_pipe

Overview:
- Parametrised fixed-point piecewise-linear sigmoid unit for the neuron activation path. Successor to the float single-FMA-per-segment activation.
- Shift-add only (no multipliers, no float IP); covers negative inputs by symmetry, y(-x) = 1 - y(x).
- Valid/ready streaming on both sides with backpressure and a sideband tag; sits between the neuron accumulator and the layer output buffer.

Parameters:
- X_W, 16, input width; signed two's complement.
- X_FRAC, 12, input fractional bits.
- Y_W, 16, output width; unsigned.
- Y_FRAC, 15, output fractional bits. 1.0 = 1<<Y_FRAC. Constraints: Y_FRAC >= X_FRAC and Y_FRAC <= Y_W-1.
- TAG_W, 8, sideband tag width (neuron index); passed through unchanged.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, x_in/tag_in valid.
- in_ready, output, 1, unit accepts this cycle.
- x_in, input, X_W, activation argument.
- tag_in, input, TAG_W, sideband.
- out_valid, output, 1, y_out/tag_out valid.
- out_ready, input, 1, downstream accepts.
- y_out, output, Y_W, sigmoid result.
- tag_out, output, TAG_W, tag aligned with y_out.

Behaviour:
- Reset: synchronous active-high on clk. Clears all stage valid bits. out_valid=0, y_out=0, tag_out=0. A transfer in flight at reset is discarded, never emitted. in_ready=1 in the cycle after reset.
- Pipeline: 3 stages, global enable en = !out_valid || out_ready; in_ready = en, combinational.
  - Stalled pipeline (en=0) holds every stage, including y_out/tag_out, stable.
  - Bubbles propagate when en=1; no bubble collapsing.
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N+3, given no stall. Throughput is 1 sample/cycle.
- Stage 1:
  - Register sign s = x_in[X_W-1].
  - a = |x_in| as X_W-bit unsigned. The most-negative input saturates to 2^(X_W-1)-1.
  - Register tag.
- Stage 2: segment select on a, in Q(X_FRAC):
  - S0, a < 1.0: f = (a>>2) + 0.5
  - S1, 1.0 <= a < 2.375: f = (a>>3) + 0.625
  - S2, 2.375 <= a < 5.0: f = (a>>5) + 0.84375
  - S3, a >= 5.0: f = 1.0
  - Boundaries belong to the upper segment.
  - Shifts truncate toward zero. The sum uses X_W+1 bits, so it cannot overflow.
- Stage 3:
  - F = f << (Y_FRAC-X_FRAC), which is exact.
  - y = s ? (1.0 - F) : F.
  - Clamp to [0, 1<<Y_FRAC]; y is never negative and never exceeds 1.0.
- Simultaneous in_valid and out_ready with a full pipeline: one sample is accepted and one is emitted in the same cycle.
- in_valid=0 inserts a bubble. tag_out follows its own sample exactly.

Optional Feature:
- Macro: SIGMOID_DERIV_EN.
- Defined:
  - Adds output port dy_out, Y_W bits, Q(Y_FRAC), equal to y*(1-y). The full product is truncated to Y_FRAC fractional bits. This is the backprop gradient term.
  - Adds a 4th pipeline stage: latency becomes 4, and y_out, tag_out and dy_out are all delayed to stay aligned.
  - dy_out resets to 0.
- Undefined: no dy_out port, no multiplier, latency 3.

Test Plan (defaults):
- Reset, then x_in = 0x0000, 0x0800, 0x1000, 0x2600, 0x5000, each with out_ready=1 → y_out = 0x4000, 0x5000, 0x6000, 0x7580, 0x8000. Each arrives exactly 3 cycles after acceptance, in order, with matching tags.
- Negative symmetry: x_in = 0xF000 (-1.0) → y_out = 0x2000. x_in = 0x8000 (most negative) → y_out = 0x0000. Also check x_in = 0x7FFF → y_out = 0x8000.
- Backpressure:
  - Stream 10 samples with tags 0..9.
  - Hold out_ready=0 for 5 cycles mid-stream → in_ready=0 during the hold and y_out/tag_out stable.
  - No sample is lost or duplicated; tags 0..9 are emitted in order.
- Back-to-back with random in_valid/out_ready over 1000 samples → every output equals the golden PWL model; throughput is 1/cycle when both sides are always on.
- Reset mid-stream with 2 samples in flight → out_valid=0 the cycle after reset; the next accepted x_in = 0x0000 yields 0x4000 with latency 3; no stale output.
- SIGMOID_DERIV_EN defined: x_in = 0x0000 → y_out = 0x4000, dy_out = 0x2000, latency 4. x_in = 0x5000 → dy_out = 0x0000.
